// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: stage-entry layout,
// default widths, the NOP encoding and exception codes.
package cpu_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int EXC_W_DEF  = 5;

  localparam logic [31:0] CMD_NOP = 32'h0;

  localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W_DEF-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W_DEF-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

  // Default-width stage entry; modules with other widths mirror this field order.
  typedef struct packed {
    logic [31:0]           cmd;
    logic [31:0]           pc;
    logic [31:0]           epc;
    logic [DATA_W_DEF-1:0] data;
    logic [EXC_W_DEF-1:0]  exc;
    logic                  bd;
  } stage_entry_t;

  function automatic int entry_w(input int data_w, input int exc_w);
    return 32 + 32 + 32 + data_w + exc_w + 1;
  endfunction

endpackage

// File: rtl/stage_slot.sv
// One stage-entry register with load, bubble-load (keeps pc/epc/bd) and clear.
module stage_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXC_W  = EXC_W_DEF,
  localparam int ENTRY_W = entry_w(DATA_W, EXC_W)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               clr,
  input  logic               load,
  input  logic               bubble,
  input  logic [ENTRY_W-1:0] d_in,
  output logic [ENTRY_W-1:0] q_out
);

  typedef struct packed {
    logic [31:0]       cmd;
    logic [31:0]       pc;
    logic [31:0]       epc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;

  entry_t in_e;
  entry_t entry_d;
  entry_t entry_q;

  assign in_e  = d_in;
  assign q_out = entry_q;

  always_comb begin
    entry_d = entry_q;
    if (clr) begin
      entry_d = '0;
    end else if (bubble) begin
      entry_d      = in_e;
      entry_d.cmd  = CMD_NOP;
      entry_d.data = '0;
      entry_d.exc  = '0;
    end else if (load) begin
      entry_d = in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (res) entry_q <= '0;
    else     entry_q <= entry_d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, and a flush that leaves a bubble carrying PC/EPC/BD.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXC_W  = EXC_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_cmd,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_epc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_cmd,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_epc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = entry_w(DATA_W, EXC_W);

  typedef struct packed {
    logic [31:0]       cmd;
    logic [31:0]       pc;
    logic [31:0]       epc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;

  entry_t in_e;
  entry_t head_e;
  entry_t skid_e;
  entry_t head_src;

  logic [ENTRY_W-1:0] head_q_w;
  logic [ENTRY_W-1:0] skid_q_w;

  logic head_vld_d, head_vld_q;
  logic skid_vld_d, skid_vld_q;
  logic head_load, head_bubble, head_from_skid, skid_load;
  logic xfer_in, xfer_out, head_free;

  assign in_e = '{cmd: in_cmd, pc: in_pc, epc: in_epc, data: in_data,
                  exc: in_exc, bd: in_bd};

  assign in_ready  = (SKID != 0) ? ~skid_vld_q : (~head_vld_q | out_ready);
  assign out_valid = head_vld_q;
  assign occupancy = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

  // Flush blocks consumption of the upstream word even though in_ready is shown.
  assign xfer_in   = in_valid & in_ready & ~flush;
  assign xfer_out  = head_vld_q & out_ready;
  assign head_free = ~head_vld_q | xfer_out;

  always_comb begin
    head_vld_d     = head_vld_q;
    skid_vld_d     = skid_vld_q;
    head_load      = 1'b0;
    head_bubble    = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      head_vld_d  = 1'b1;
      head_bubble = 1'b1;
      skid_vld_d  = 1'b0;
    end else if (head_free) begin
      if (skid_vld_q) begin
        head_load      = 1'b1;
        head_from_skid = 1'b1;
        head_vld_d     = 1'b1;
        skid_load      = xfer_in;
        skid_vld_d     = xfer_in;
      end else begin
        head_load  = xfer_in;
        head_vld_d = xfer_in;
      end
    end else if (xfer_in) begin
      skid_load  = 1'b1;
      skid_vld_d = 1'b1;
    end
    if (SKID == 0) begin
      skid_load  = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign head_src = head_from_skid ? skid_e : in_e;

  stage_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_head (
    .clk    (clk),
    .res    (res),
    .clr    (1'b0),
    .load   (head_load),
    .bubble (head_bubble),
    .d_in   (head_src),
    .q_out  (head_q_w)
  );

  generate
    if (SKID != 0) begin : g_skid
      stage_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
        .clk    (clk),
        .res    (res),
        .clr    (flush),
        .load   (skid_load),
        .bubble (1'b0),
        .d_in   (in_e),
        .q_out  (skid_q_w)
      );
    end else begin : g_no_skid
      assign skid_q_w = '0;
    end
  endgenerate

  assign head_e = head_q_w;
  assign skid_e = skid_q_w;

  assign out_cmd  = head_e.cmd;
  assign out_pc   = head_e.pc;
  assign out_epc  = head_e.epc;
  assign out_data = head_e.data;
  assign out_exc  = head_e.exc;
  assign out_bd   = head_e.bd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance plus a SKID=0 instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        res, flush, in_valid, in_bd;
  logic [31:0] in_cmd, in_pc, in_epc;
  logic [95:0] in_data;
  logic [4:0]  in_exc;

  logic        in_ready, out_valid, out_ready, out_bd;
  logic [31:0] out_cmd, out_pc, out_epc;
  logic [95:0] out_data;
  logic [4:0]  out_exc;
  logic [1:0]  occupancy;

  logic        in_ready0, out_valid0, out_ready0, out_bd0;
  logic [31:0] out_cmd0, out_pc0, out_epc0;
  logic [95:0] out_data0;
  logic [4:0]  out_exc0;
  logic [1:0]  occupancy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .EXC_W(5), .SKID(1)) u_dut (
    .clk(clk), .res(res), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_pc(in_pc), .in_epc(in_epc), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .out_pc(out_pc), .out_epc(out_epc), .out_data(out_data),
    .out_exc(out_exc), .out_bd(out_bd), .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(96), .EXC_W(5), .SKID(0)) u_dut0 (
    .clk(clk), .res(res), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_cmd(in_cmd), .in_pc(in_pc), .in_epc(in_epc), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_cmd(out_cmd0), .out_pc(out_pc0), .out_epc(out_epc0), .out_data(out_data0),
    .out_exc(out_exc0), .out_bd(out_bd0), .occupancy(occupancy0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cmd_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_cmd   = cmd_of(pc);
    in_epc   = pc + 32'd4;
    in_data  = {pc, ~pc, pc};
    in_exc   = pc[6:2];
    in_bd    = pc[2];
  endtask

  initial begin
    // Reset with random inputs
    res = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = $urandom_range(0, 1);
    out_ready0 = 1'b1;
    in_cmd = $urandom; in_pc = $urandom; in_epc = $urandom;
    in_data = {$urandom, $urandom, $urandom}; in_exc = 5'($urandom); in_bd = 1'b1;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_cmd", out_cmd, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready0", in_ready0, 1);

    // Streaming with out_ready=1
    res = 1'b0; out_ready = 1'b1;
    drive(32'h3000);
    step();
    check("str0_valid", out_valid, 1);
    check("str0_pc", out_pc, 32'h3000);
    check("str0_occ", occupancy, 1);
    drive(32'h3004);
    step();
    check("str1_pc", out_pc, 32'h3004);
    check("str1_cmd", out_cmd, 32'hA5A5_3004);
    check("str1_occ", occupancy, 1);
    drive(32'h3008);
    step();
    check("str2_pc", out_pc, 32'h3008);
    check("str2_data", out_data, {32'h3008, 32'hFFFF_CFF7, 32'h3008});
    check("str2_epc", out_epc, 32'h300C);
    in_valid = 1'b0;
    step();
    check("str_drain_valid", out_valid, 0);
    check("str_drain_hold_pc", out_pc, 32'h3008);
    check("str_drain_occ", occupancy, 0);

    // Backpressure on the SKID=1 instance
    out_ready = 1'b0;
    drive(32'h3000);
    step();
    check("bp0_occ", occupancy, 1);
    check("bp0_in_ready", in_ready, 1);
    drive(32'h3004);
    step();
    check("bp1_occ", occupancy, 2);
    check("bp1_in_ready", in_ready, 0);
    check("bp1_pc", out_pc, 32'h3000);
    drive(32'h3008);
    step();
    check("bp2_occ", occupancy, 2);
    check("bp2_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp3_head_pc", out_pc, 32'h3000);
    step();
    check("bp4_pc", out_pc, 32'h3004);
    check("bp4_occ", occupancy, 1);
    check("bp4_in_ready", in_ready, 1);
    step();
    check("bp5_pc", out_pc, 32'h3008);
    check("bp5_cmd", out_cmd, 32'hA5A5_3008);
    check("bp5_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("bp6_occ", occupancy, 0);

    // Flush with two entries held
    out_ready = 1'b0;
    drive(32'h3100);
    step();
    drive(32'h3104);
    step();
    check("fl_pre_occ", occupancy, 2);
    flush = 1'b1; in_valid = 1'b1;
    in_pc = 32'h4180; in_epc = 32'h4184; in_bd = 1'b1;
    in_cmd = 32'hDEAD_BEEF; in_exc = 5'd12; in_data = {3{32'h1234_5678}};
    step();
    check("fl_cmd", out_cmd, 0);
    check("fl_exc", out_exc, 0);
    check("fl_data", out_data, 0);
    check("fl_pc", out_pc, 32'h4180);
    check("fl_epc", out_epc, 32'h4184);
    check("fl_bd", out_bd, 1);
    check("fl_valid", out_valid, 1);
    check("fl_occ", occupancy, 1);
    check("fl_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("fl_hold_valid", out_valid, 1);
    check("fl_hold_pc", out_pc, 32'h4180);
    out_ready = 1'b1;
    step();
    check("fl_taken_valid", out_valid, 0);

    // Reset together with flush
    out_ready = 1'b0; out_ready0 = 1'b0;
    drive(32'h3200);
    step();
    drive(32'h3204);
    step();
    check("rf_pre_occ", occupancy, 2);
    res = 1'b1; flush = 1'b1;
    step();
    check("rf_valid", out_valid, 0);
    check("rf_pc", out_pc, 0);
    check("rf_epc", out_epc, 0);
    check("rf_bd", out_bd, 0);
    check("rf_cmd", out_cmd, 0);
    check("rf_occ", occupancy, 0);
    check("rf_valid0", out_valid0, 0);
    res = 1'b0; flush = 1'b0;
    drive(32'h3300);
    step();
    check("post_rst_pc", out_pc, 32'h3300);
    check("post_rst_occ", occupancy, 1);

    // SKID=0 instance: combinational in_ready and replace-on-transfer
    in_valid = 1'b0;
    #1;
    check("s0_full_pc", out_pc0, 32'h3300);
    check("s0_in_ready_low", in_ready0, 0);
    out_ready0 = 1'b1;
    #1;
    check("s0_in_ready_high", in_ready0, 1);
    drive(32'h3304);
    step();
    check("s0_rep_pc", out_pc0, 32'h3304);
    check("s0_rep_valid", out_valid0, 1);
    check("s0_rep_occ", occupancy0, 1);
    drive(32'h3308);
    step();
    check("s0_next_pc", out_pc0, 32'h3308);
    check("s0_next_valid", out_valid0, 1);
    in_valid = 1'b0;
    step();
    check("s0_drain_valid", out_valid0, 0);
    check("s0_drain_occ", occupancy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
